// File: rtl/imm_target_pkg.sv
// Shared types and constants for the immediate/branch target table.
package imm_target_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Value returned for an entry that has not been written since reset.
    localparam int unsigned UNLOADED_VAL = 1;

endpackage

// File: rtl/imm_target_mem.sv
// Target entry storage with per-entry loaded bits, one write port and one
// registered read port. The read result holds when no read is requested.
module imm_target_mem
    import imm_target_pkg::*;
#(
    parameter int PC_WIDTH = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [PC_WIDTH-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [PC_WIDTH-1:0] rd_entry,
    output logic                rd_loaded
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [PC_WIDTH-1:0] DEFAULT_VAL = PC_WIDTH'(UNLOADED_VAL);

    logic [PC_WIDTH-1:0] entry_q [DEPTH];
    logic [PC_WIDTH-1:0] entry_d [DEPTH];
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [PC_WIDTH-1:0] rd_entry_q, rd_entry_d;
    logic                rd_loaded_q, rd_loaded_d;

    // Next-state for storage and the registered read port.
    always_comb begin
        entry_d     = entry_q;
        valid_d     = valid_q;
        rd_entry_d  = rd_entry_q;
        rd_loaded_d = rd_loaded_q;
        if (wr_en) begin
            entry_d[wr_addr] = wr_data;
            valid_d[wr_addr] = 1'b1;
        end
        if (rd_en) begin
            rd_entry_d  = entry_q[rd_addr];
            rd_loaded_d = valid_q[rd_addr];
        end
    end

    // Storage flops; reset loads the default value so misses need no extra mux.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= DEFAULT_VAL;
            end
            valid_q     <= '0;
            rd_entry_q  <= DEFAULT_VAL;
            rd_loaded_q <= 1'b1;
        end else begin
            entry_q     <= entry_d;
            valid_q     <= valid_d;
            rd_entry_q  <= rd_entry_d;
            rd_loaded_q <= rd_loaded_d;
        end
    end

    assign rd_entry  = rd_entry_q;
    assign rd_loaded = rd_loaded_q;

endmodule

// File: rtl/imm_target_table.sv
// Immediate/branch target table: streaming loader plus absolute or
// PC-relative lookup. Optional feature macro: IMM_TARGET_TABLE_RELATIVE_EN
// (defined: rd_rel selects PC-relative mode; undefined: absolute only).
//
// state | meaning
// IDLE  | lookups accepted, waiting for ld_start
// LOAD  | accepting load beats at ptr, lookups stalled
module imm_target_table
    import imm_target_pkg::*;
#(
    parameter int PC_WIDTH = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                ld_start,
    input  logic [ADDR_W-1:0]   ld_base,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [PC_WIDTH-1:0] ld_data,
    input  logic                ld_abort,
    output logic                ld_done,
    input  logic                rd_req,
    output logic                rd_ready,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                rd_rel,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic                rd_valid,
    output logic [PC_WIDTH-1:0] rd_data,
    output logic                rd_miss
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                ld_done_q, ld_done_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_en;
    logic                rd_accept;
    logic [PC_WIDTH-1:0] rd_entry;
    logic                rd_loaded;

    assign ld_ready  = (state_q == LOAD);
    assign rd_ready  = (state_q == IDLE);
    assign rd_accept = rd_req && rd_ready;
    // An abort beat is dropped even if ld_valid is high.
    assign wr_en     = (state_q == LOAD) && ld_valid && !ld_abort;

    // Load FSM next-state, pointer advance and done pulse.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ld_done_d  = 1'b0;
        rd_valid_d = rd_accept;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d = LOAD;
                    ptr_d   = ld_base;
                end
            end
            LOAD: begin
                if (ld_abort) begin
                    state_d   = IDLE;
                    ld_done_d = 1'b1;
                end else if (ld_valid) begin
                    if (ptr_q == '1) begin
                        state_d   = IDLE;
                        ld_done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and strobe registers; reset mid-load drops the load with no done pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            ld_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ld_done_q  <= ld_done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    imm_target_mem #(
        .PC_WIDTH (PC_WIDTH),
        .ADDR_W   (ADDR_W)
    ) u_mem (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .wr_en     (wr_en),
        .wr_addr   (ptr_q),
        .wr_data   (ld_data),
        .rd_en     (rd_accept),
        .rd_addr   (rd_addr),
        .rd_entry  (rd_entry),
        .rd_loaded (rd_loaded)
    );

`ifdef IMM_TARGET_TABLE_RELATIVE_EN
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                rel_q, rel_d;

    // Capture PC and mode with the accepted lookup so the sum tracks the read.
    always_comb begin
        pc_d  = pc_q;
        rel_d = rel_q;
        if (rd_accept) begin
            pc_d  = pc_in;
            rel_d = rd_rel;
        end
    end

    // Lookup context registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q  <= '0;
            rel_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            rel_q <= rel_d;
        end
    end

    // Two's-complement add wraps naturally at PC_WIDTH bits.
    assign rd_data = rel_q ? (pc_q + rd_entry) : rd_entry;
`else
    logic unused_rel_inputs;
    assign unused_rel_inputs = &{1'b0, rd_rel, pc_in};
    assign rd_data = rd_entry;
`endif

    assign ld_done  = ld_done_q;
    assign rd_valid = rd_valid_q;
    assign rd_miss  = !rd_loaded;

endmodule

// File: tb/tb_imm_target_table.sv
// Self-checking bench for imm_target_table: directed scenarios plus random
// loads/lookups against an array model of the table contents.
module tb_imm_target_table;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       ld_start, ld_valid, ld_ready, ld_abort, ld_done;
    logic [3:0] ld_base, rd_addr;
    logic [7:0] ld_data, pc_in, rd_data;
    logic       rd_req, rd_ready, rd_rel, rd_valid, rd_miss;

    int n_chk  = 0;
    int n_fail = 0;

    int model_val [16];
    bit model_ld  [16];
    logic [7:0] pat [16] = '{8'h34, 8'h01, 8'h5A, 8'hC3, 8'h7E, 8'h12, 8'h99, 8'hE0,
                             8'h07, 8'h4D, 8'hB2, 8'h66, 8'hF1, 8'h28, 8'hAF, 8'h8B};

    always #5 Clk = ~Clk;

    imm_target_table #(.PC_WIDTH(8), .ADDR_W(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_abort(ld_abort), .ld_done(ld_done),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_rel(rd_rel),
        .pc_in(pc_in), .rd_valid(rd_valid), .rd_data(rd_data), .rd_miss(rd_miss)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input int addr, input bit rel, input int pc);
        int v;
        v = model_ld[addr] ? model_val[addr] : 1;
`ifdef IMM_TARGET_TABLE_RELATIVE_EN
        if (rel) v = (pc + v) % 256;
`endif
        return v[7:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            model_val[i] = 1;
            model_ld[i]  = 0;
        end
    endtask

    task automatic lookup(input int addr, input bit rel, input int pc);
        logic [7:0] e;
        bit         m;
        @(negedge Clk);
        rd_req = 1; rd_addr = addr[3:0]; rd_rel = rel; pc_in = pc[7:0];
        e = exp_data(addr, rel, pc);
        m = !model_ld[addr];
        chk("rd_ready_idle", rd_ready, 1);
        @(posedge Clk); #1;
        rd_req = 0;
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, e);
        chk("rd_miss", rd_miss, m);
        @(posedge Clk); #1;
        chk("rd_valid_low", rd_valid, 0);
        chk("rd_data_hold", rd_data, e);
    endtask

    task automatic do_load(input int base, input int abort_at, input bit gaps, input bit use_pat,
                           input int stop_after, input bit probe_rd, input bit rd_at_start,
                           input int rd_a);
        int ptr, beats, cyc;
        bit done, vld, ab;
        logic [7:0] dat, e;
        bit m;
        @(negedge Clk);
        ld_start = 1; ld_base = base[3:0];
        if (rd_at_start) begin
            rd_req = 1; rd_addr = rd_a[3:0]; rd_rel = 0; pc_in = 0;
            e = exp_data(rd_a, 0, 0);
            m = !model_ld[rd_a];
        end
        @(posedge Clk); #1;
        ld_start = 0; rd_req = 0;
        if (rd_at_start) begin
            chk("start_rd_valid", rd_valid, 1);
            chk("start_rd_data", rd_data, e);
            chk("start_rd_miss", rd_miss, m);
        end
        chk("ld_ready_load", ld_ready, 1);
        chk("rd_ready_load", rd_ready, 0);
        ptr = base; beats = 0; done = 0; cyc = 0;
        while (!done && cyc < 200) begin
            if (stop_after >= 0 && beats == stop_after) break;
            @(negedge Clk);
            cyc++;
            vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            ab  = (beats == abort_at);
            if (ab) vld = 1;
            dat = use_pat ? pat[beats] : 8'($urandom_range(0, 255));
            ld_valid = vld; ld_data = dat; ld_abort = ab;
            if (probe_rd && cyc == 1) begin
                rd_req = 1; rd_addr = 4'($urandom_range(0, 15));
                chk("probe_rd_ready", rd_ready, 0);
            end
            @(posedge Clk); #1;
            if (probe_rd && cyc == 1) begin
                rd_req = 0;
                chk("probe_rd_valid", rd_valid, 0);
            end
            if (ab) begin
                done = 1;
            end else if (vld) begin
                model_val[ptr] = dat;
                model_ld[ptr]  = 1;
                beats++;
                if (ptr == 15) done = 1;
                else ptr++;
            end
            chk("ld_done", ld_done, done);
        end
        ld_valid = 0; ld_abort = 0;
        if (!done && stop_after < 0) chk("ld_timeout", 0, 1);
        if (done) begin
            @(posedge Clk); #1;
            chk("ld_done_pulse_end", ld_done, 0);
            chk("ld_ready_idle", ld_ready, 0);
            chk("rd_ready_back", rd_ready, 1);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 0;
        model_clear();
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 1);
        chk("rst_rd_miss", rd_miss, 0);
        chk("rst_ld_done", ld_done, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_rd_ready", rd_ready, 1);
        @(negedge Clk);
        Reset_n = 1;
    endtask

    initial begin
        Reset_n = 0; ld_start = 0; ld_base = 0; ld_valid = 0; ld_data = 0; ld_abort = 0;
        rd_req = 0; rd_addr = 0; rd_rel = 0; pc_in = 0;
        model_clear();
        repeat (2) @(posedge Clk);
        do_reset();

        // unloaded entry reads as 1 with miss; relative unloaded gives pc+1
        lookup(3, 0, 0);
        lookup(9, 1, 8'h40);

        // full 16-beat load from base 0, abort in IDLE ignored beforehand
        @(negedge Clk); ld_abort = 1;
        @(posedge Clk); #1; ld_abort = 0;
        chk("abort_idle_ignored", ld_ready, 0);
        do_load(0, -1, 0, 1, -1, 0, 0, 0);
        lookup(0, 0, 0);
        lookup(15, 0, 0);

        // relative mode with negative entry and with PC wrap
        do_load(14, -1, 0, 0, -1, 0, 0, 0);
        model_val[14] = 8'hE0; model_val[15] = 8'h07;
        do_reset();
        @(negedge Clk); ld_start = 1; ld_base = 14;
        @(posedge Clk); #1; ld_start = 0;
        @(negedge Clk); ld_valid = 1; ld_data = 8'hE0;
        @(posedge Clk); #1;
        @(negedge Clk); ld_data = 8'h07;
        @(posedge Clk); #1; ld_valid = 0;
        chk("rel_load_done", ld_done, 1);
        model_val[14] = 8'hE0; model_ld[14] = 1;
        model_val[15] = 8'h07; model_ld[15] = 1;
        lookup(14, 1, 8'h10);
        lookup(15, 1, 8'hFC);
        lookup(14, 0, 8'h10);

        // abort on third beat at base 5; includes a lookup on the ld_start cycle
        do_reset();
        do_load(5, 2, 0, 0, -1, 1, 1, 5);
        lookup(5, 0, 0);
        lookup(6, 0, 0);
        lookup(7, 0, 0);

        // reset mid-load discards everything, no done pulse
        do_load(0, -1, 0, 0, 3, 0, 0, 0);
        @(negedge Clk); Reset_n = 0; model_clear();
        #1;
        chk("midrst_ld_done", ld_done, 0);
        chk("midrst_ld_ready", ld_ready, 0);
        @(negedge Clk); Reset_n = 1;
        @(posedge Clk); #1;
        chk("midrst_no_done", ld_done, 0);
        for (int a = 0; a < 16; a++) lookup(a, 0, 0);

        // randomized mix of loads and lookups
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_load($urandom_range(0, 15),
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
                        1, 0, -1, $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 15));
            end else begin
                lookup($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 255));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
